// File: rtl/prim_reg_bus_adapter_if.sv
// Request/response bus between a register-block requester and
// prim_reg_bus_adapter.
//
// Request channel (master -> slave, valid/ready):
//   req_valid, req_write, req_addr[AW], req_wdata[DW], req_be[DW/8]
//   req_ready (slave -> master)
// Response channel (slave -> master, valid/ready):
//   rsp_valid, rsp_rdata[DW], rsp_error
//   rsp_ready (master -> slave)
interface prim_reg_bus_adapter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_be;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_be,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_error,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_error,
    input  rsp_ready
  );
endinterface

// File: rtl/prim_reg_bus_adapter.sv
// Register bus adapter: turns a single-outstanding valid/ready register
// request into one-hot write/read strobes for a bank of prim_subreg
// instances, byte-merges partial writes with the current register value and
// returns read data / error status on a registered response channel.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   bus        request/response channel (slave side)
//   reg_we     one-hot write strobe, one bit per register
//   reg_re     one-hot read strobe (for read-to-clear subregs)
//   reg_wdata  byte-merged write data to the subreg wd inputs
//   reg_rdata  concatenated subreg qs; register i at [i*DW +: DW]
module prim_reg_bus_adapter #(
  parameter int unsigned NumRegs  = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter bit          StrictBe = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  prim_reg_bus_adapter_if.slave bus,
  output logic [NumRegs-1:0]    reg_we,
  output logic [NumRegs-1:0]    reg_re,
  output logic [DW-1:0]         reg_wdata,
  input  logic [NumRegs*DW-1:0] reg_rdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = AW - 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RSP  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;

  logic [IW-1:0] idx;
  logic          aligned;
  logic          in_range;
  logic          hit;
  logic          be_err;
  logic          err;
  logic          accept;
  logic [DW-1:0] cur_val;

  // Handshake outputs. req_ready depends only on flopped state (and reset),
  // so there is no combinational path from rsp_ready.
  assign bus.req_ready = rst_ni & (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  assign accept = bus.req_valid & bus.req_ready;

  // Address / access decode.
  always_comb begin
    idx      = bus.req_addr[AW-1:2];
    aligned  = (bus.req_addr[1:0] == 2'b00);
    in_range = ({1'b0, idx} < (IW+1)'(NumRegs));
    hit      = aligned & in_range;
    // An all-zero byte enable never writes anything useful and is always
    // flagged; StrictBe additionally rejects any partial write.
    be_err   = bus.req_write &
               ((bus.req_be == '0) | (StrictBe & (bus.req_be != '1)));
    err      = ~hit | be_err;
  end

  // Current value of the addressed register. Built as an explicit mux so an
  // out-of-range index yields 0 instead of an X from an out-of-bounds slice.
  always_comb begin
    cur_val = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (idx == IW'(i)) begin
        cur_val = reg_rdata[i*DW +: DW];
      end
    end
  end

  // Byte-lane merge of write data with the current register contents.
  always_comb begin
    reg_wdata = '0;
    if (in_range) begin
      for (int unsigned k = 0; k < BW; k++) begin
        reg_wdata[8*k +: 8] = bus.req_be[k] ? bus.req_wdata[8*k +: 8]
                                            : cur_val[8*k +: 8];
      end
    end
  end

  // Strobes fire only in the accept cycle of an error-free request.
  always_comb begin
    reg_we = '0;
    reg_re = '0;
    if (accept && !err) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (idx == IW'(i)) begin
          reg_we[i] = bus.req_write;
          reg_re[i] = ~bus.req_write;
        end
      end
    end
  end

  // Response FSM. Read data is captured in the accept cycle, i.e. before any
  // same-cycle write or read-to-clear side effect lands in the subreg.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RSP;
          rsp_error_d = err;
          rsp_rdata_d = (!err && !bus.req_write) ? cur_val : '0;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  a_strobe_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(reg_we | reg_re));

  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.rsp_valid && !bus.rsp_ready |=>
      $stable(bus.rsp_rdata) && $stable(bus.rsp_error));

  a_no_strobe_in_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.rsp_valid |-> ((reg_we | reg_re) == '0));

endmodule

// File: tb/tb_prim_reg_bus_adapter.sv
module tb_prim_reg_bus_adapter;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prim_reg_bus_adapter_if #(.AW(AW), .DW(DW)) bus0 ();
  prim_reg_bus_adapter_if #(.AW(AW), .DW(DW)) bus1 ();

  logic [NR-1:0]    we0, re0, we1, re1;
  logic [DW-1:0]    wd0, wd1;
  logic [DW-1:0]    regs [NR];
  logic [NR*DW-1:0] qs;

  int vectors     = 0;
  int miscompares = 0;

  always_comb begin
    qs = '0;
    for (int unsigned i = 0; i < NR; i++) qs[i*DW +: DW] = regs[i];
  end

  prim_reg_bus_adapter #(.NumRegs(NR), .AW(AW), .DW(DW), .StrictBe(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0),
    .reg_we(we0), .reg_re(re0), .reg_wdata(wd0), .reg_rdata(qs));

  prim_reg_bus_adapter #(.NumRegs(NR), .AW(AW), .DW(DW), .StrictBe(1'b1)) dut_strict (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1),
    .reg_we(we1), .reg_re(re1), .reg_wdata(wd1), .reg_rdata(qs));

  // Reference model: plain arithmetic on the byte address.
  function automatic logic m_err(input logic strict, input logic wr,
                                 input logic [AW-1:0] addr, input logic [3:0] be);
    int unsigned a;
    logic hit;
    a   = addr;
    hit = (a % 4 == 0) && (a / 4 < NR);
    return !hit || (wr && be == 4'h0) || (strict && wr && be != 4'hF);
  endfunction

  function automatic logic [DW-1:0] m_merge(input logic [DW-1:0] nw,
                                            input logic [DW-1:0] old,
                                            input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [3:0] be);
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wd;
    bus0.req_be    = be;
    bus0.req_valid = 1'b1;
  endtask

  task automatic rand_req(output logic wr, output logic [AW-1:0] addr,
                          output logic [DW-1:0] wd, output logic [3:0] be);
    wr   = 1'($urandom_range(1));
    addr = ($urandom_range(3) != 0) ? AW'(4 * $urandom_range(NR-1))
                                    : AW'($urandom_range(255));
    wd   = $urandom;
    be   = ($urandom_range(1) == 1) ? 4'hF : 4'($urandom_range(15));
    drive_req(wr, addr, wd, be);
  endtask

  // Waits (bounded) for a negedge where the adapter will accept on bus0.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus0.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    regs[1] = 32'hDEADBEEF;
    bus0.rsp_ready = 1'b1;
    drive_req(1'b0, 8'h04, '0, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, we0, re0} !==
        {1'b0, 32'h0, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b d=%h e=%b we=%b re=%b expected 0",
               bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, we0, re0);
    end
    step();
    rst_n = 1'b1;
    wait_ready(ok);
    vectors++;
    if (!ok || {we0, re0} !== {8'h00, 8'b0000_0010}) begin
      miscompares++;
      $display("FAIL reset_first_read_strobe: got ok=%b we=%b re=%b expected re=00000010",
               ok, we0, re0);
    end
    step();
    bus0.req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, bus0.req_ready, we0 | re0} !==
        {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_first_rsp: got v=%b d=%h e=%b rdy=%b expected v=1 d=deadbeef e=0 rdy=0",
               bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, bus0.req_ready);
    end
    step();
  endtask

  task automatic test_write_merge();
    bit ok;
    regs[2] = 32'hAABBCCDD;
    drive_req(1'b1, 8'h08, 32'h11223344, 4'h5);
    wait_ready(ok);
    vectors++;
    if (!ok || {we0, re0, wd0} !== {8'b0000_0100, 8'h00, 32'hAA22CC44}) begin
      miscompares++;
      $display("FAIL write_merge_strobe: got ok=%b we=%b re=%b wd=%h expected we=00000100 wd=aa22cc44",
               ok, we0, re0, wd0);
    end
    step();
    bus0.req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error} !== {1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL write_merge_rsp: got v=%b d=%h e=%b expected v=1 d=0 e=0",
               bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error);
    end
    step();
  endtask

  task automatic test_errors();
    bit ok;
    logic          c_wr [3] = '{1'b0, 1'b0, 1'b1};
    logic [AW-1:0] c_ad [3] = '{8'h06, AW'(NR * 4), 8'h00};
    logic [3:0]    c_be [3] = '{4'hF, 4'hF, 4'h0};
    for (int c = 0; c < 3; c++) begin
      drive_req(c_wr[c], c_ad[c], 32'hCAFEF00D, c_be[c]);
      wait_ready(ok);
      vectors++;
      if (!ok || (we0 | re0) !== 8'h00) begin
        miscompares++;
        $display("FAIL error_no_strobe[%0d]: got ok=%b we=%b re=%b expected none",
                 c, ok, we0, re0);
      end
      step();
      bus0.req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error} !== {1'b1, 32'h0, 1'b1}) begin
        miscompares++;
        $display("FAIL error_rsp[%0d]: got v=%b d=%h e=%b expected v=1 d=0 e=1",
                 c, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error);
      end
      step();
    end
  endtask

  task automatic test_strict_be();
    logic [AW-1:0] c_ad [2] = '{8'h0C, 8'h10};
    logic [3:0]    c_be [2] = '{4'h3, 4'hF};
    logic [NR-1:0] exp_we;
    logic          exp_err;
    bit ok;
    for (int c = 0; c < 2; c++) begin
      exp_err = m_err(1'b1, 1'b1, c_ad[c], c_be[c]);
      exp_we  = exp_err ? '0 : (NR'(1) << (c_ad[c] / 4));
      bus1.req_write = 1'b1;
      bus1.req_addr  = c_ad[c];
      bus1.req_wdata = 32'h5A5A0FF0;
      bus1.req_be    = c_be[c];
      bus1.req_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus1.req_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      vectors++;
      if (!ok || {we1, re1} !== {exp_we, 8'h00} ||
          (!exp_err && wd1 !== 32'h5A5A0FF0)) begin
        miscompares++;
        $display("FAIL strict_be_strobe[%0d]: got ok=%b we=%b re=%b wd=%h expected we=%b",
                 c, ok, we1, re1, wd1, exp_we);
      end
      step();
      bus1.req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_error} !== {1'b1, 32'h0, exp_err}) begin
        miscompares++;
        $display("FAIL strict_be_rsp[%0d]: got v=%b d=%h e=%b expected v=1 d=0 e=%b",
                 c, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_error, exp_err);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    regs[3] = 32'h12345678;
    bus0.rsp_ready = 1'b0;
    drive_req(1'b0, 8'h0C, '0, 4'hF);
    wait_ready(ok);
    vectors++;
    if (!ok || {we0, re0} !== {8'h00, 8'b0000_1000}) begin
      miscompares++;
      $display("FAIL bp_first_strobe: got ok=%b we=%b re=%b expected re=00001000", ok, we0, re0);
    end
    step();
    drive_req(1'b0, 8'h00, '0, 4'hF);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      vectors++;
      if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, bus0.req_ready, we0 | re0} !==
          {1'b1, 32'h12345678, 1'b0, 1'b0, 8'h00}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b stb=%b expected v=1 d=12345678 e=0 rdy=0 stb=0",
                 n, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, bus0.req_ready, we0 | re0);
      end
      step();
      regs[3] = $urandom;
    end
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.req_ready, we0 | re0} !== {1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL bp_release_cycle: got v=%b rdy=%b stb=%b expected v=1 rdy=0 stb=0",
               bus0.rsp_valid, bus0.req_ready, we0 | re0);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.req_ready, we0, re0} !== {1'b0, 1'b1, 8'h00, 8'h01}) begin
      miscompares++;
      $display("FAIL bp_second_accept: got v=%b rdy=%b we=%b re=%b expected v=0 rdy=1 re=00000001",
               bus0.rsp_valid, bus0.req_ready, we0, re0);
    end
    step();
    bus0.req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error} !== {1'b1, regs[0], 1'b0}) begin
      miscompares++;
      $display("FAIL bp_second_rsp: got v=%b d=%h e=%b expected v=1 d=%h e=0",
               bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, regs[0]);
    end
    step();
  endtask

  // Mixed traffic checked against a response queue. Without stress the
  // requester keeps req_valid high and rsp_ready tied high; with stress
  // both sides insert random gaps and registers change under the adapter.
  task automatic run_traffic(input int n, input bit stress);
    rsp_t q[$];
    rsp_t r;
    int sent = 0, got = 0, cyc = 0, last_acc = -1;
    logic cur_wr;
    logic [AW-1:0] cur_ad;
    logic [DW-1:0] cur_wd;
    logic [3:0] cur_be;
    logic [NR-1:0] ws, exp_we, exp_re;
    logic e, accepted;
    int unsigned a;
    bus0.rsp_ready = 1'b1;
    rand_req(cur_wr, cur_ad, cur_wd, cur_be);
    while (got < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      accepted = 1'b0;
      vectors++;
      if ({bus0.req_ready, bus0.rsp_valid} !== {q.size() == 0, q.size() != 0}) begin
        miscompares++;
        $display("FAIL traffic_handshake: got rdy=%b v=%b expected pending=%0d",
                 bus0.req_ready, bus0.rsp_valid, q.size());
      end
      if (q.size() != 0 && bus0.rsp_valid === 1'b1) begin
        vectors++;
        if ({bus0.rsp_rdata, bus0.rsp_error} !== {q[0].rdata, q[0].err}) begin
          miscompares++;
          $display("FAIL traffic_rsp: got d=%h e=%b expected d=%h e=%b",
                   bus0.rsp_rdata, bus0.rsp_error, q[0].rdata, q[0].err);
        end
        if (bus0.rsp_ready) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (bus0.req_valid && bus0.req_ready === 1'b1) begin
        a      = cur_ad;
        e      = m_err(1'b0, cur_wr, cur_ad, cur_be);
        ws     = e ? '0 : (NR'(1) << (a / 4));
        exp_we = cur_wr ? ws : '0;
        exp_re = cur_wr ? '0 : ws;
        vectors++;
        if ({we0, re0} !== {exp_we, exp_re} ||
            (!e && cur_wr && wd0 !== m_merge(cur_wd, regs[(a / 4) % NR], cur_be))) begin
          miscompares++;
          $display("FAIL traffic_strobe: addr=%h wr=%b be=%h got we=%b re=%b wd=%h expected we=%b re=%b",
                   cur_ad, cur_wr, cur_be, we0, re0, wd0, exp_we, exp_re);
        end
        if (!stress && last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc != 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles expected 2", cyc - last_acc);
          end
        end
        last_acc = cyc;
        r.err    = e;
        r.rdata  = (!e && !cur_wr) ? regs[(a / 4) % NR] : '0;
        q.push_back(r);
        sent++;
        accepted = 1'b1;
      end else begin
        vectors++;
        if ((we0 | re0) !== 8'h00) begin
          miscompares++;
          $display("FAIL traffic_idle_strobe: got we=%b re=%b expected none", we0, re0);
        end
      end
      step();
      if (stress) regs[$urandom_range(NR-1)] = $urandom;
      if (accepted) bus0.req_valid = 1'b0;
      if (!bus0.req_valid && sent < n && (!stress || $urandom_range(1) == 1))
        rand_req(cur_wr, cur_ad, cur_wd, cur_be);
      if (stress) bus0.rsp_ready = 1'($urandom_range(1));
    end
    vectors++;
    if (got != n) begin
      miscompares++;
      $display("FAIL traffic_timeout: got %0d responses expected %0d", got, n);
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    run_traffic(12, 1'b0);
  endtask

  task automatic test_random();
    run_traffic(150, 1'b1);
  endtask

  task automatic test_reset_mid_rsp();
    bit ok;
    bus0.rsp_ready = 1'b0;
    drive_req(1'b0, 8'h08, '0, 4'hF);
    wait_ready(ok);
    step();
    bus0.req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (!ok || bus0.rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_enter_rsp: got ok=%b v=%b expected v=1", ok, bus0.rsp_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus0.rsp_valid, we0, re0} !== {1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL rst_mid_async_drop: got v=%b we=%b re=%b expected all 0",
               bus0.rsp_valid, we0, re0);
    end
    drive_req(1'b0, 8'h04, '0, 4'hF);
    @(negedge clk);
    vectors++;
    if ((we0 | re0) !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid_no_strobe: got we=%b re=%b expected none", we0, re0);
    end
    step();
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, we0 | re0} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL rst_mid_release: got rdy=%b v=%b d=%h e=%b stb=%b expected rdy=1 v=0 d=0 e=0 stb=0",
               bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, we0 | re0);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.req_be    = '0;
    bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0;
    bus1.req_write = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    bus1.req_be    = '0;
    bus1.rsp_ready = 1'b1;

    test_reset();
    test_write_merge();
    test_errors();
    test_strict_be();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
